// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the default operand width.
package seq_multiplier_pkg;

  localparam int N_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_multiplier_adder_n.sv
// n-bit ripple-carry adder with carry-out; purely combinational, used for the
// accumulate step of the shift-add multiplier.
module adder_n
  import seq_multiplier_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[n];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned sequential multiplier: one multiplier bit per clock, LSB first,
// producing an exact 2n-bit product after n RUN cycles.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);

  localparam int CW = $clog2(n) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [n-1:0]    mcand;
  logic [n-1:0]    mplier;
  logic [2*n-1:0]  acc;
  logic [2*n-1:0]  acc_nxt;
  logic [n-1:0]    addend;
  logic [n-1:0]    sum;
  logic            carry;
  logic            last;
  logic            accept;

  assign last   = (cnt == CW'(n - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Add into the upper half, then shift {carry, acc} right by one.
  assign addend = mplier[0] ? mcand : '0;

  adder_n #(.n(n)) u_adder (
    .x    (acc[2*n-1:n]),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  assign acc_nxt = (2*n)'({carry, sum, acc[n-1:0]} >> 1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state == RUN) begin
      cnt    <= cnt + CW'(1);
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      // product only changes on the final RUN edge and otherwise holds
      if (last) product <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed scenarios plus random
// operands compared against plain integer multiplication.
module tb_seq_multiplier;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.n(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[2*N-1:0];
  endfunction

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy samples until done is seen; returns at the done negedge.
  task automatic wait_done(output int run_cycles, output bit timeout);
    int guard;
    run_cycles = 0; timeout = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      if (busy) run_cycles++;
      @(negedge clk);
      guard++;
    end
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (product !== '0) begin fails++; $display("FAIL reset_product: got %h expected 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int run; bit to;
    issue(16'd3, 16'd5);
    wait_done(run, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout: got no done expected done"); end
    tests++; if (run !== 16) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 16", run); end
    tests++; if (product !== 32'h0000000F) begin fails++; $display("FAIL basic_product: got %h expected 0000000f", product); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_max();
    int run; bit to;
    issue(16'hFFFF, 16'hFFFF);
    wait_done(run, to);
    tests++; if (to || busy !== 1'b0) begin fails++; $display("FAIL max_busy_at_done: got busy=%b timeout=%b expected 0 0", busy, to); end
    tests++; if (product !== 32'hFFFE0001) begin fails++; $display("FAIL max_product: got %h expected fffe0001", product); end
  endtask

  task automatic test_zero_ignored();
    int run; int pre; bit to; bit extra;
    issue(16'd0, 16'h1234);
    pre = busy ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) pre++;
    end
    start = 1'b1; a = 16'd7; b = 16'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(run, to);
    tests++; if (to || (pre + run) !== 16) begin fails++; $display("FAIL ignored_run_length: got %0d expected 16", pre + run); end
    tests++; if (product !== '0) begin fails++; $display("FAIL zero_product: got %h expected 0", product); end
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    tests++; if (extra !== 1'b0) begin fails++; $display("FAIL ignored_extra_op: got activity=%b expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int run; int edges; bit to; bit hold_bad;
    issue(16'd2, 16'd3);
    wait_done(run, to);
    tests++; if (to || product !== 32'd6) begin fails++; $display("FAIL b2b_first_product: got %h expected 6", product); end
    start = 1'b1; a = 16'd4; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    edges = 1; hold_bad = 1'b0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0", busy, done); end
    while (!done && edges < 100) begin
      if (product !== 32'd6) hold_bad = 1'b1;
      @(negedge clk);
      edges++;
    end
    tests++; if (hold_bad) begin fails++; $display("FAIL b2b_product_hold: got changed expected 6 held"); end
    tests++; if (edges !== 17) begin fails++; $display("FAIL b2b_latency: got %0d expected 17", edges); end
    tests++; if (product !== 32'd20) begin fails++; $display("FAIL b2b_second_product: got %h expected 14", product); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid_run();
    int run; bit to; bit saw;
    issue(16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done); end
    tests++; if (product !== '0) begin fails++; $display("FAIL abort_product: got %h expected 0", product); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy || product !== '0) saw = 1'b1;
    end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL abort_no_done: got activity=%b expected 0", saw); end
    issue(16'd10, 16'd10);
    wait_done(run, to);
    tests++; if (to || product !== 32'd100) begin fails++; $display("FAIL after_reset_product: got %h expected 64", product); end
  endtask

  task automatic test_random();
    int run; bit to;
    logic [N-1:0] ra, rb;
    logic [2*N-1:0] exp_p;
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i == 0) rb = 16'h8000;
      if (i == 1) ra = 16'h0001;
      exp_p = ref_mul(ra, rb);
      issue(ra, rb);
      wait_done(run, to);
      tests++;
      if (to || run !== 16 || product !== exp_p) begin
        fails++;
        $display("FAIL random_%0d: a=%h b=%h got %h run=%0d expected %h run=16", i, ra, rb, product, run, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: n, 16, operand width in bits; the product is 2n bits wide, so n=16 feeds the team's 32-bit Register directly.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 a  input  n  multiplicand (unsigned); sampled with an accepted start.
REQ-006 b  input  n  multiplier (unsigned); sampled with an accepted start.
REQ-007 busy  output  1  high while a multiplication is in progress (state RUN).
REQ-008 done  output  1  single-cycle pulse; product is newly valid.
REQ-009 product  output  2n  result register; downstream Register captures it on done.

Function
REQ-010 Algorithm: unsigned shift-add, one multiplier bit per clock, LSB first.
REQ-011 FSM states: IDLE, RUN, DONE.
REQ-012 Transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after exactly n RUN cycles.
- DONE -> RUN on start=1.
- DONE -> IDLE otherwise.
REQ-013 Accepted start: latch a, b; clear the accumulator and the bit counter.
REQ-014 Each RUN cycle:
- if the current multiplier LSB = 1, add the multiplicand to the upper n bits of the accumulator, keeping the carry as bit 2n;
- shift {carry, accumulator} right by one;
- increment the counter.
REQ-015 Counter width: ceil(log2(n))+1 bits; terminal value is n-1 on the last RUN cycle; no wrap-around within an operation.
REQ-016 Latency: if start is sampled at edge E0, done=1 in the cycle after edge En, i.e. n+1 edges after acceptance.
REQ-017 product loads the final accumulator on the RUN->DONE edge only; it holds otherwise, including through the next RUN.
REQ-018 busy=1 exactly when the state is RUN; done=1 exactly when the state is DONE.
REQ-019 start while busy=1 is ignored, with no effect on operands, counter or the result.
REQ-020 Start held high in the DONE cycle begins the next operation back-to-back; done stays a single-cycle pulse.
REQ-021 No overflow is possible: the full 2n-bit product is always exact.

Reset
REQ-022 rst_n=0 immediately forces:
- state IDLE;
- busy=0, done=0, product=0;
- accumulator, latched operands and counter = 0.
REQ-023 rst_n=0 during RUN aborts the operation; no done is produced for it and product stays 0.
REQ-024 The first start is accepted on the first rising edge with rst_n=1.

Structure
REQ-025 A shared package holds:
- FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
- default operand width constant (16).
REQ-026 Sub-module adder_n is the n-bit ripple-carry adder with carry-out, used for the accumulate step; it is the only sub-module.
REQ-027 Sequential state (FSM, counter, accumulator, operand latches, product) lives only in seq_multiplier.

Verification
REQ-028 Basic product (n=16): a=3, b=5, start 1 cycle -> busy high for 16 cycles, then done pulse 1 cycle, product=32'h0000000F.
REQ-029 Maximum operands: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 at done; busy deasserts the same edge done asserts.
REQ-030 Zero operand and ignored start:
- a=0, b=16'h1234 -> product=0;
- start pulsed mid-RUN with a=7, b=7 -> ignored, single done, product=0.
REQ-031 Back-to-back start:
- a=2, b=3, then start held in the DONE cycle with a=4, b=5;
- first done shows product=6, which holds during the second RUN;
- second done 17 edges later shows product=20.
REQ-032 Reset mid-operation:
- rst_n low 8 cycles into RUN -> busy, done and product go 0 asynchronously and no done follows;
- after release, a=10, b=10 -> product=100.
